acc_16b: RTL
============

ACC_16B -- requirements
Module: acc_16b

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 clear  input  1  synchronous abort/restart of the current accumulation.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_data  input  16  unsigned operand to add.
REQ-007 in_last  input  1  marks final operand of a packet.
REQ-008 in_ready  output  1  block accepts an operand this cycle.
REQ-009 out_valid  output  1  packet result available.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_sum  output  16  accumulated sum modulo 2^16.
REQ-012 out_ovf  output  1  sticky: at least one carry-out occurred during the packet.
REQ-013 out_count  output  8  operands accepted in the packet, saturating at 255.

Function
REQ-014 The block SHALL use the team's 16-bit carry-lookahead adder (sum_16b) as its only adder: a = accumulator, b = in_data, c_in = 0; its sum and Cout are registered here.
REQ-015 FSM states SHALL be IDLE, ACC, DONE.
REQ-016 Transfer on input: in_valid & in_ready at a rising edge.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, 0 in DONE; it is a decode of state only (no dependency on out_ready).
REQ-018 out_valid SHALL be 1 only in DONE.
REQ-019 IDLE: on transfer, acc <= in_data (0 + in_data through adder), ovf <= 0, count <= 1; next state ACC, or DONE if in_last.
REQ-020 ACC: on transfer, acc <= acc + in_data mod 2^16, ovf <= ovf | Cout, count <= min(count+1, 255); next state DONE if in_last, else ACC.
REQ-021 No transfer in IDLE/ACC: all registers hold.
REQ-022 Latency: the transfer carrying in_last at edge k SHALL give out_valid = 1 from the cycle after edge k with the final sum, ovf, count.
REQ-023 DONE: out_sum/out_ovf/out_count SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-024 DONE with out_ready = 1: next state IDLE; acc, ovf, count cleared to 0 at that edge.
REQ-025 Outputs out_sum, out_ovf, out_count SHALL directly reflect acc, ovf, count registers in every state.
REQ-026 Wrap-around: 0xFFFF + 0x0001 SHALL give acc = 0x0000 and set ovf; ovf never clears within a packet.
REQ-027 Count saturation: count SHALL hold at 255 on further transfers; accumulation continues.
REQ-028 clear = 1 (no rst) in any state SHALL force IDLE, acc = 0, ovf = 0, count = 0 at the edge; any simultaneous transfer is discarded; a pending result in DONE is dropped.
REQ-029 Single-operand packet (in_last on first transfer in IDLE) SHALL be legal: result = that operand, ovf = 0, count = 1.
REQ-030 in_data/in_last SHALL be ignored whenever in_valid = 0 or in_ready = 0.

Reset
REQ-031 rst = 1 at an edge SHALL force state IDLE, acc = 0x0000, ovf = 0, count = 0 regardless of all other inputs, including clear and mid-packet state.
REQ-032 Output values during and right after reset: in_ready = 1, out_valid = 0, out_sum = 0x0000, out_ovf = 0, out_count = 0x00.
REQ-033 rst has priority over clear; clear has priority over transfers and out_ready.

Verification
REQ-034 Packet 0x0010, 0x0020, 0x0003(last), out_ready = 1 -> one cycle after last transfer out_valid = 1, out_sum = 0x0033, out_ovf = 0, out_count = 3; IDLE next cycle.
REQ-035 Packet 0xFFFF, 0x0002(last) -> out_sum = 0x0001, out_ovf = 1, out_count = 2.
REQ-036 Result held with out_ready = 0 for 5 cycles while in_valid = 1 -> out_* stable, in_ready = 0, no input consumed; out_ready = 1 -> IDLE, in_ready = 1.
REQ-037 300 transfers of 0x0001, last on 300th -> out_sum = 0x012C, out_count = 255, out_ovf = 0.
REQ-038 clear mid-packet after 0x1234, then 0x0005(last) -> out_sum = 0x0005, out_count = 1; same via rst mid-packet -> identical result and reset values per REQ-032.
REQ-039 rst and clear together with in_valid = 1 -> reset values, input discarded.

Source files
------------

// File: rtl/acc_16b.sv
// Packet accumulator: sums 16-bit operands through a carry-lookahead adder.
// Tracks a sticky carry-out and a saturating operand count per packet.
module sum_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        Cout
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [3:0]  w_gp;
    logic [3:0]  w_gg;
    logic [4:0]  w_gc;

    assign w_p = a ^ b;
    assign w_g = a & b;

    genvar j;
    generate
        for (j = 0; j < 4; j++) begin : g_grp
            assign w_gp[j] = &w_p[4*j +: 4];
            assign w_gg[j] = w_g[4*j+3]
                           | (w_p[4*j+3] & w_g[4*j+2])
                           | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                           | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1]
                              & w_g[4*j]);
        end
    endgenerate

    // Second-level lookahead across the four groups
    assign w_gc[0] = c_in;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0])
                   | (w_gp[1] & w_gp[0] & c_in);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1])
                   | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2])
                   | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c_in);

    always_comb begin
        logic w_c;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            w_c = w_gc[k];
            for (int i = 0; i < 4; i++) begin
                sum[4*k+i] = w_p[4*k+i] ^ w_c;
                w_c = w_g[4*k+i] | (w_p[4*k+i] & w_c);
            end
        end
    end

    assign Cout = w_gc[4];
endmodule

module acc_16b (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_ovf,
    output logic [7:0]  out_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [15:0] r_acc;
    logic [15:0] w_acc_n;
    logic        r_ovf;
    logic        w_ovf_n;
    logic [7:0]  r_count;
    logic [7:0]  w_count_n;
    logic [15:0] w_sum;
    logic        w_cout;
    logic        w_xfer;

    sum_16b u_add (
        .a    (r_acc),
        .b    (in_data),
        .c_in (1'b0),
        .sum  (w_sum),
        .Cout (w_cout)
    );

    assign in_ready  = (r_state != DONE);
    assign out_valid = (r_state == DONE);
    assign w_xfer    = in_valid & in_ready;

    always_comb begin
        w_state_n = r_state;
        w_acc_n   = r_acc;
        w_ovf_n   = r_ovf;
        w_count_n = r_count;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_acc_n   = w_sum;
                    w_ovf_n   = 1'b0;
                    w_count_n = 8'd1;
                    w_state_n = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_xfer) begin
                    w_acc_n   = w_sum;
                    w_ovf_n   = r_ovf | w_cout;
                    if (r_count != 8'hFF)
                        w_count_n = r_count + 8'd1;
                    w_state_n = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_acc_n   = '0;
                    w_ovf_n   = 1'b0;
                    w_count_n = '0;
                    w_state_n = IDLE;
                end
            end
            default: begin
                w_acc_n   = '0;
                w_ovf_n   = 1'b0;
                w_count_n = '0;
                w_state_n = IDLE;
            end
        endcase
        // Abort wins over any transfer or result hand-off
        if (clear) begin
            w_acc_n   = '0;
            w_ovf_n   = 1'b0;
            w_count_n = '0;
            w_state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_n;
            r_acc   <= w_acc_n;
            r_ovf   <= w_ovf_n;
            r_count <= w_count_n;
        end
    end

    assign out_sum   = r_acc;
    assign out_ovf   = r_ovf;
    assign out_count = r_count;
endmodule
